mem_dump_arbiter: RTL and testbench

- Owns the data-memory port of the MEM stage and shares it between two requesters: the pipeline load/store path and the debug unit.
- In normal operation the pipeline accesses pass straight through to the memory.
- On a debug dump request, the block stalls the pipeline and waits for the in-flight pipeline access to retire. It then walks every memory word from address 0 upward and hands each word to the debug unit through a valid/ready handshake.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/mem_dump_seq.sv | 89 ++++++++
 rtl/mem_dump_arbiter.sv | 89 ++++++++
 tb/tb_mem_dump_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage memory port: load/store size codes
// and the dump sequencer state encoding.
package mem_pkg;

  localparam logic [1:0] WR_SRC_BYTE  = 2'b00;
  localparam logic [1:0] WR_SRC_HALF  = 2'b01;
  localparam logic [1:0] WR_SRC_WORD  = 2'b10;

  localparam logic [2:0] RD_SRC_BYTE  = 3'b000;
  localparam logic [2:0] RD_SRC_HALF  = 3'b001;
  localparam logic [2:0] RD_SRC_WORD  = 3'b010;
  localparam logic [2:0] RD_SRC_BYTEU = 3'b100;
  localparam logic [2:0] RD_SRC_HALFU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_PIPE = 3'd1,
    ST_DUMP_RD   = 3'd2,
    ST_DUMP_SEND = 3'd3,
    ST_DONE      = 3'd4
  } dump_state_e;

endpackage

// File: rtl/mem_dump_seq.sv
// Dump sequencer: FSM, word-address counter and the registered debug-side
// outputs. The top level uses o_state/o_cnt to steer the memory port.
module mem_dump_seq
  import mem_pkg::*;
#(
  parameter int IO_BUS_SIZE   = 32,
  parameter int MEM_ADDR_SIZE = 5
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_dump_start,
  input  logic                     i_pipe_req,
  input  logic                     i_dbg_ready,
  input  logic [IO_BUS_SIZE-1:0]   i_mem_rd_data,
  output dump_state_e              o_state,
  output logic [MEM_ADDR_SIZE-1:0] o_cnt,
  output logic [IO_BUS_SIZE-1:0]   o_dbg_data,
  output logic [MEM_ADDR_SIZE-1:0] o_dbg_addr,
  output logic                     o_dbg_valid,
  output logic                     o_dbg_busy,
  output logic                     o_dbg_done
);

  localparam logic [MEM_ADDR_SIZE-1:0] LastAddr = '1;

  dump_state_e              state_q, state_d;
  logic [MEM_ADDR_SIZE-1:0] cnt_q, cnt_d;
  logic [IO_BUS_SIZE-1:0]   data_q;
  logic [MEM_ADDR_SIZE-1:0] addr_q;
  logic                     valid_q, busy_q, done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE:      if (i_dump_start) state_d = ST_WAIT_PIPE;
      ST_WAIT_PIPE: if (!i_pipe_req) state_d = ST_DUMP_RD;
      ST_DUMP_RD:   state_d = ST_DUMP_SEND;
      ST_DUMP_SEND: begin
        // Termination is decided by the last-address compare, never by wrap.
        if (i_dbg_ready) begin
          if (cnt_q == LastAddr) begin
            state_d = ST_DONE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = ST_DUMP_RD;
          end
        end
      end
      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= (state_d == ST_DUMP_SEND);
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
      if (state_q == ST_DUMP_RD) begin
        data_q <= i_mem_rd_data;
        addr_q <= cnt_q;
      end
    end
  end

  assign o_state     = state_q;
  assign o_cnt       = cnt_q;
  assign o_dbg_data  = data_q;
  assign o_dbg_addr  = addr_q;
  assign o_dbg_valid = valid_q;
  assign o_dbg_busy  = busy_q;
  assign o_dbg_done  = done_q;

endmodule

// File: rtl/mem_dump_arbiter.sv
// MEM-stage data-memory port arbiter: pipeline pass-through in normal
// operation, sequential full-memory dump to the debug unit on request.
module mem_dump_arbiter
  import mem_pkg::*;
#(
  parameter int IO_BUS_SIZE   = 32,
  parameter int MEM_ADDR_SIZE = 5
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_pipe_req,
  input  logic                     i_pipe_wr_rd,
  input  logic [MEM_ADDR_SIZE-1:0] i_pipe_addr,
  input  logic [IO_BUS_SIZE-1:0]   i_pipe_wr_data,
  input  logic [1:0]               i_pipe_wr_src,
  input  logic [2:0]               i_pipe_rd_src,
  output logic [IO_BUS_SIZE-1:0]   o_pipe_rd_data,
  output logic                     o_pipe_gnt,
  output logic                     o_pipe_stall,
  input  logic                     i_dbg_dump_start,
  output logic [IO_BUS_SIZE-1:0]   o_dbg_data,
  output logic [MEM_ADDR_SIZE-1:0] o_dbg_addr,
  output logic                     o_dbg_valid,
  input  logic                     i_dbg_ready,
  output logic                     o_dbg_busy,
  output logic                     o_dbg_done,
  output logic [MEM_ADDR_SIZE-1:0] o_mem_addr,
  output logic                     o_mem_wr_rd,
  output logic [IO_BUS_SIZE-1:0]   o_mem_wr_data,
  output logic [1:0]               o_mem_wr_src,
  output logic [2:0]               o_mem_rd_src,
  input  logic [IO_BUS_SIZE-1:0]   i_mem_rd_data
);

  dump_state_e              state;
  logic [MEM_ADDR_SIZE-1:0] cnt;
  logic                     busy;
  logic                     passThru;
  logic                     dumping;

  mem_dump_seq #(
    .IO_BUS_SIZE  (IO_BUS_SIZE),
    .MEM_ADDR_SIZE(MEM_ADDR_SIZE)
  ) u_seq (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_dump_start (i_dbg_dump_start),
    .i_pipe_req   (i_pipe_req),
    .i_dbg_ready  (i_dbg_ready),
    .i_mem_rd_data(i_mem_rd_data),
    .o_state      (state),
    .o_cnt        (cnt),
    .o_dbg_data   (o_dbg_data),
    .o_dbg_addr   (o_dbg_addr),
    .o_dbg_valid  (o_dbg_valid),
    .o_dbg_busy   (busy),
    .o_dbg_done   (o_dbg_done)
  );

  // Reset gates the combinational path so every output reads 0 while it is held.
  assign passThru = !i_reset && ((state == ST_IDLE) || (state == ST_WAIT_PIPE));
  assign dumping  = (state == ST_DUMP_RD) || (state == ST_DUMP_SEND) || (state == ST_DONE);

  always_comb begin
    o_mem_addr     = '0;
    o_mem_wr_rd    = 1'b0;
    o_mem_wr_data  = '0;
    o_mem_wr_src   = '0;
    o_mem_rd_src   = '0;
    o_pipe_gnt     = 1'b0;
    o_pipe_rd_data = '0;
    if (passThru) begin
      o_mem_addr     = i_pipe_addr;
      o_mem_wr_rd    = i_pipe_req & i_pipe_wr_rd;
      o_mem_wr_data  = i_pipe_wr_data;
      o_mem_wr_src   = i_pipe_wr_src;
      o_mem_rd_src   = i_pipe_rd_src;
      o_pipe_gnt     = i_pipe_req;
      o_pipe_rd_data = i_mem_rd_data;
    end else if (dumping) begin
      o_mem_addr   = cnt;
      o_mem_rd_src = RD_SRC_WORD;
    end
  end

  assign o_pipe_stall = busy;
  assign o_dbg_busy   = busy;

endmodule

// File: tb/tb_mem_dump_arbiter.sv
// Randomized scoreboard bench for mem_dump_arbiter with a word-array memory
// model behind the DUT and a shadow copy holding the expected contents.
module tb_mem_dump_arbiter;
  import mem_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk;
  logic          i_reset;
  logic          i_pipe_req;
  logic          i_pipe_wr_rd;
  logic [AW-1:0] i_pipe_addr;
  logic [DW-1:0] i_pipe_wr_data;
  logic [1:0]    i_pipe_wr_src;
  logic [2:0]    i_pipe_rd_src;
  logic [DW-1:0] o_pipe_rd_data;
  logic          o_pipe_gnt;
  logic          o_pipe_stall;
  logic          i_dbg_dump_start;
  logic [DW-1:0] o_dbg_data;
  logic [AW-1:0] o_dbg_addr;
  logic          o_dbg_valid;
  logic          i_dbg_ready;
  logic          o_dbg_busy;
  logic          o_dbg_done;
  logic [AW-1:0] o_mem_addr;
  logic          o_mem_wr_rd;
  logic [DW-1:0] o_mem_wr_data;
  logic [1:0]    o_mem_wr_src;
  logic [2:0]    o_mem_rd_src;
  logic [DW-1:0] i_mem_rd_data;

  mem_dump_arbiter #(.IO_BUS_SIZE(DW), .MEM_ADDR_SIZE(AW)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_pipe_req(i_pipe_req), .i_pipe_wr_rd(i_pipe_wr_rd), .i_pipe_addr(i_pipe_addr),
    .i_pipe_wr_data(i_pipe_wr_data), .i_pipe_wr_src(i_pipe_wr_src), .i_pipe_rd_src(i_pipe_rd_src),
    .o_pipe_rd_data(o_pipe_rd_data), .o_pipe_gnt(o_pipe_gnt), .o_pipe_stall(o_pipe_stall),
    .i_dbg_dump_start(i_dbg_dump_start), .o_dbg_data(o_dbg_data), .o_dbg_addr(o_dbg_addr),
    .o_dbg_valid(o_dbg_valid), .i_dbg_ready(i_dbg_ready), .o_dbg_busy(o_dbg_busy),
    .o_dbg_done(o_dbg_done), .o_mem_addr(o_mem_addr), .o_mem_wr_rd(o_mem_wr_rd),
    .o_mem_wr_data(o_mem_wr_data), .o_mem_wr_src(o_mem_wr_src), .o_mem_rd_src(o_mem_rd_src),
    .i_mem_rd_data(i_mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External memory: combinational read, write on the rising edge
  logic [DW-1:0] memArr [DEPTH];
  assign i_mem_rd_data = memArr[o_mem_addr];
  always @(posedge clk) if (o_mem_wr_rd) memArr[o_mem_addr] <= o_mem_wr_data;

  logic [DW-1:0] shadow [DEPTH];

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } dumpWord_t;
  dumpWord_t sbQ[$];

  int vectors    = 0;
  int miscompares = 0;
  int doneCount  = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every accepted dump word is popped from the scoreboard and compared
  initial begin
    forever begin
      @(negedge clk);
      if (o_dbg_done) doneCount++;
      if (o_dbg_valid && i_dbg_ready) begin
        if (sbQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected dump word: got addr %0d data 0x%0h, expected none", o_dbg_addr, o_dbg_data);
        end else begin
          dumpWord_t exp;
          exp = sbQ.pop_front();
          checkOutput("dump addr", o_dbg_addr, exp.addr);
          checkOutput("dump data", o_dbg_data, exp.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time budget");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "[TB] watchdog");
  end

  // One pipeline cycle, entered and left at posedge+1
  task automatic applyStimulus(input logic req, input logic wr, input logic [AW-1:0] addr,
                               input logic [DW-1:0] data, input logic expectGnt, input logic expectStall);
    i_pipe_req     = req;
    i_pipe_wr_rd   = wr;
    i_pipe_addr    = addr;
    i_pipe_wr_data = data;
    i_pipe_wr_src  = WR_SRC_WORD;
    i_pipe_rd_src  = RD_SRC_WORD;
    @(negedge clk);
    checkOutput("pipe gnt", o_pipe_gnt, req & expectGnt);
    checkOutput("pipe stall", o_pipe_stall, expectStall);
    checkOutput("mem wr_rd", o_mem_wr_rd, req & wr & expectGnt);
    if (req && expectGnt) checkOutput("mem addr", o_mem_addr, addr);
    if (req && expectGnt && !wr) checkOutput("pipe rd data", o_pipe_rd_data, shadow[addr]);
    if (req && expectGnt && wr) shadow[addr] = data;
    @(posedge clk); #1;
    i_pipe_req = 1'b0;
  endtask

  // Start pulse plus reqCycles of pipeline traffic that must drain first
  task automatic startDump(input int reqCycles);
    for (int k = 0; k < reqCycles; k++) begin
      i_dbg_dump_start = (k == 0);
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, DEPTH - 1)), $urandom, 1'b1, k > 0);
      i_dbg_dump_start = 1'b0;
    end
    if (reqCycles == 0) begin
      i_dbg_dump_start = 1'b1;
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
      i_dbg_dump_start = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) sbQ.push_back('{addr: i[AW-1:0], data: shadow[i]});
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("dump_rd valid low", o_dbg_valid, 0);
    checkOutput("dump_rd mem addr/wr/src", {o_mem_addr, o_mem_wr_rd, o_mem_rd_src}, {5'd0, 1'b0, RD_SRC_WORD});
    @(posedge clk); #1;
  endtask

  task automatic runDump(input bit randReady, input int holdAddr, input int holdCycles,
                         input int injectAddr, input int resetAddr,
                         output int firstValid, output int doneAt, output int validCycles);
    int  cyc      = 0;
    int  holdLeft = holdCycles;
    bit  seenDone = 0;
    bit  aborted  = 0;
    bit  injected = 0;
    bit  holding;
    bit  injecting;
    firstValid  = -1;
    doneAt      = -1;
    validCycles = 0;
    while (!seenDone && cyc < 400) begin
      holding   = 0;
      injecting = 0;
      if (resetAddr >= 0 && o_dbg_valid && o_dbg_addr == resetAddr[AW-1:0]) begin
        i_pipe_req = 1'b1; i_pipe_wr_rd = 1'b1; i_pipe_addr = 5'd7;
        i_pipe_wr_data = 32'hA5A5_5A5A; i_dbg_dump_start = 1'b1;
        #2 i_reset = 1'b1;
        #1;
        checkOutput("reset pipe outs", {o_pipe_rd_data, o_pipe_gnt, o_pipe_stall}, '0);
        checkOutput("reset dbg outs", {o_dbg_data, o_dbg_addr, o_dbg_valid, o_dbg_busy, o_dbg_done}, '0);
        checkOutput("reset mem outs", {o_mem_addr, o_mem_wr_rd, o_mem_wr_data, o_mem_wr_src, o_mem_rd_src}, '0);
        @(posedge clk); #1;
        checkOutput("reset held idle", {o_dbg_busy, o_dbg_valid, o_pipe_stall, o_mem_wr_rd}, '0);
        i_pipe_req = 1'b0; i_pipe_wr_rd = 1'b0; i_dbg_dump_start = 1'b0;
        #2 i_reset = 1'b0;
        sbQ.delete();
        @(posedge clk); #1;
        aborted = 1;
        break;
      end
      if (o_dbg_valid && o_dbg_addr == holdAddr[AW-1:0] && holdAddr >= 0 && holdLeft > 0) begin
        i_dbg_ready = 1'b0;
        holdLeft--;
        holding = 1;
      end else begin
        i_dbg_ready = randReady ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (injectAddr >= 0 && !injected && o_dbg_valid && o_dbg_addr == injectAddr[AW-1:0]) begin
        i_pipe_req = 1'b1; i_pipe_wr_rd = 1'b1; i_pipe_addr = 5'd5;
        i_pipe_wr_data = 32'hBAD0_0BAD; i_dbg_dump_start = 1'b1;
        injected  = 1;
        injecting = 1;
      end
      @(negedge clk);
      if (holding) begin
        checkOutput("backpressure valid", o_dbg_valid, 1);
        checkOutput("backpressure addr", o_dbg_addr, holdAddr);
        checkOutput("backpressure data", o_dbg_data, shadow[holdAddr]);
      end
      if (injecting) begin
        checkOutput("blocked gnt", o_pipe_gnt, 0);
        checkOutput("blocked mem write", o_mem_wr_rd, 0);
        checkOutput("blocked stall", o_pipe_stall, 1);
      end
      if (o_dbg_valid) begin
        validCycles++;
        if (firstValid < 0) firstValid = cyc;
      end
      if (o_dbg_done) begin
        doneAt   = cyc;
        seenDone = 1;
      end
      @(posedge clk); #1;
      i_pipe_req = 1'b0; i_pipe_wr_rd = 1'b0; i_dbg_dump_start = 1'b0;
      cyc++;
    end
    i_dbg_ready = 1'b0;
    if (!seenDone && !aborted) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL dump timeout: got no done after %0d cycles, expected done", cyc);
    end
    if (!aborted) begin
      @(negedge clk);
      checkOutput("post-dump busy/stall", {o_dbg_busy, o_pipe_stall}, 2'b00);
      checkOutput("scoreboard drained", sbQ.size(), 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int fv, da, vc, doneBase;
    i_reset = 1'b1;
    i_pipe_req = 1'b0; i_pipe_wr_rd = 1'b0; i_pipe_addr = '0; i_pipe_wr_data = '0;
    i_pipe_wr_src = '0; i_pipe_rd_src = '0; i_dbg_dump_start = 1'b0; i_dbg_ready = 1'b0;
    #13;
    checkOutput("por pipe outs", {o_pipe_rd_data, o_pipe_gnt, o_pipe_stall}, '0);
    checkOutput("por dbg outs", {o_dbg_data, o_dbg_addr, o_dbg_valid, o_dbg_busy, o_dbg_done}, '0);
    checkOutput("por mem outs", {o_mem_addr, o_mem_wr_rd, o_mem_wr_data, o_mem_wr_src, o_mem_rd_src}, '0);
    #10 i_reset = 1'b0;
    @(posedge clk); #1;

    $display("[TB] pass-through");
    applyStimulus(1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 5'd3, '0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b1, i[AW-1:0], i * 4 + 1, 1'b1, 1'b0);

    $display("[TB] full dump, ready high");
    doneBase = doneCount;
    startDump(0);
    runDump(1'b0, -1, 0, -1, -1, fv, da, vc);
    checkOutput("first valid after dump_rd", fv, 0);
    checkOutput("valid cycle count", vc, DEPTH);
    checkOutput("done offset", da, 2 * DEPTH - 1);
    checkOutput("done pulses", doneCount - doneBase, 1);

    $display("[TB] random pass-through");
    for (int i = 0; i < 24; i++)
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, DEPTH - 1)),
                    $urandom, 1'b1, 1'b0);

    $display("[TB] backpressure at addr 10");
    doneBase = doneCount;
    startDump(0);
    runDump(1'b1, 10, 7, -1, -1, fv, da, vc);
    checkOutput("bp done pulses", doneCount - doneBase, 1);

    $display("[TB] drain, blocked write, ignored restart");
    doneBase = doneCount;
    startDump(4);
    runDump(1'b1, -1, 0, 2, -1, fv, da, vc);
    checkOutput("drain first valid", fv, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("no restart done pulses", doneCount - doneBase, 1);
    checkOutput("no restart busy", o_dbg_busy, 0);
    applyStimulus(1'b1, 1'b0, 5'd5, '0, 1'b1, 1'b0);

    $display("[TB] reset mid-dump");
    doneBase = doneCount;
    startDump(0);
    runDump(1'b0, -1, 0, -1, 17, fv, da, vc);
    checkOutput("reset no done", doneCount - doneBase, 0);
    startDump(0);
    runDump(1'b1, -1, 0, -1, -1, fv, da, vc);
    checkOutput("fresh dump done pulses", doneCount - doneBase, 1);
    applyStimulus(1'b1, 1'b0, 5'd7, '0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
